// File: rtl/apple_tracker.sv
// rtl/apple_tracker.sv - snake apple-eating, growth, score and respawn handshake tracker
// Optional body collision / game-over support: define APPLE_TRACKER_BODY_COLLISION_EN.
`default_nettype none

module apple_tracker #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int XW       = 4,
  parameter int YW       = 4,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int SCORE_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         move_tick,
  input  logic [XW-1:0]                head_x,
  input  logic [YW-1:0]                head_y,
  input  logic [GRID_W-1:0][GRID_H-1:0] apple_map,
  input  logic                         spawn_ack,
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
  input  logic [GRID_W-1:0][GRID_H-1:0] body_map,
  output logic                         game_over,
`endif
  output logic                         eat_pulse,
  output logic [LEN_W-1:0]             snake_len,
  output logic [SCORE_W-1:0]           score,
  output logic                         spawn_req,
  output logic                         game_won
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    SPAWN = 2'd1,
    WON   = 2'd2,
    LOST  = 2'd3
  } state_t;

  state_t state;

  // An out-of-range head must never index the bitmaps into a hit.
  logic head_in_range;
  logic hit;
  logic grows_to_win;
  logic score_full;

  assign head_in_range = (32'(head_x) < 32'(GRID_W)) && (32'(head_y) < 32'(GRID_H));
  assign hit           = move_tick && head_in_range && apple_map[head_x][head_y];
  assign grows_to_win  = (snake_len == LEN_W'(MAX_LEN - 1));
  assign score_full    = (score == {SCORE_W{1'b1}});

`ifdef APPLE_TRACKER_BODY_COLLISION_EN
  logic body_hit;
  assign body_hit = move_tick && head_in_range && body_map[head_x][head_y];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      eat_pulse <= 1'b0;
      snake_len <= LEN_W'(INIT_LEN);
      score     <= '0;
      spawn_req <= 1'b0;
      game_won  <= 1'b0;
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
      game_over <= 1'b0;
`endif
    end else begin
      eat_pulse <= 1'b0;
      case (state)
        PLAY: begin
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
          if (body_hit) begin
            // Collision wins over an apple in the same cell: no growth, no score.
            game_over <= 1'b1;
            state     <= LOST;
          end else
`endif
          if (hit) begin
            eat_pulse <= 1'b1;
            if (!score_full) begin
              score <= score + SCORE_W'(1);
            end
            if (grows_to_win) begin
              snake_len <= LEN_W'(MAX_LEN);
              game_won  <= 1'b1;
              state     <= WON;
            end else begin
              snake_len <= snake_len + LEN_W'(1);
              spawn_req <= 1'b1;
              state     <= SPAWN;
            end
          end
        end
        SPAWN: begin
          // Bitmap may still show the eaten apple; ignore moves until the placer acks.
          if (spawn_ack) begin
            spawn_req <= 1'b0;
            state     <= PLAY;
          end
        end
        WON: begin
          spawn_req <= 1'b0;
          game_won  <= 1'b1;
        end
        default: begin
          spawn_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apple_tracker.sv
// tb/tb_apple_tracker.sv - vector table, corner sequences and randomized model check for apple_tracker
module tb_apple_tracker;

  logic                 clk;
  logic                 reset;
  logic                 move_tick;
  logic [3:0]           head_x;
  logic [3:0]           head_y;
  logic [15:0][15:0]    apple_map;
  logic                 spawn_ack;
  logic                 eat_pulse, spawn_req, game_won;
  logic [4:0]           snake_len;
  logic [7:0]           score;
  logic                 eat_pulse2, spawn_req2, game_won2;
  logic [4:0]           snake_len2;
  logic [1:0]           score2;
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
  logic [15:0][15:0]    body_map;
  logic                 game_over, game_over2;
`endif

  int nvec = 0;
  int nmis = 0;

  apple_tracker dut (
    .clk(clk), .reset(reset), .move_tick(move_tick),
    .head_x(head_x), .head_y(head_y), .apple_map(apple_map), .spawn_ack(spawn_ack),
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
    .body_map(body_map), .game_over(game_over),
`endif
    .eat_pulse(eat_pulse), .snake_len(snake_len), .score(score),
    .spawn_req(spawn_req), .game_won(game_won)
  );

  // Narrow score so saturation is reachable before the win length.
  apple_tracker #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .move_tick(move_tick),
    .head_x(head_x), .head_y(head_y), .apple_map(apple_map), .spawn_ack(spawn_ack),
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
    .body_map(body_map), .game_over(game_over2),
`endif
    .eat_pulse(eat_pulse2), .snake_len(snake_len2), .score(score2),
    .spawn_req(spawn_req2), .game_won(game_won2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit tick; bit ack; bit apple;
    int ax; int ay; int hx; int hy;
    bit e_eat; int e_len; int e_score; bit e_req; bit e_won;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit tick, input int hx, input int hy, input bit ack);
    reset     = rst;
    move_tick = tick;
    head_x    = 4'(hx);
    head_y    = 4'(hy);
    spawn_ack = ack;
  endtask

  task automatic chk_all(input string tag, input bit e_eat, input int e_len, input int e_score,
                         input bit e_req, input bit e_won);
    chk({tag, ".eat"}, int'(eat_pulse), int'(e_eat));
    chk({tag, ".len"}, int'(snake_len), e_len);
    chk({tag, ".score"}, int'(score), e_score);
    chk({tag, ".req"}, int'(spawn_req), int'(e_req));
    chk({tag, ".won"}, int'(game_won), int'(e_won));
  endtask

  task automatic add(input bit rst, input bit tick, input bit ack, input bit apple,
                     input int ax, input int ay, input int hx, input int hy,
                     input bit e_eat, input int e_len, input int e_score, input bit e_req, input bit e_won);
    vec_t t;
    t = '{rst, tick, ack, apple, ax, ay, hx, hy, e_eat, e_len, e_score, e_req, e_won};
    vecs.push_back(t);
  endtask

  // Reference model state: length, eaten count, awaiting-respawn flag, win flag.
  int m_len, m_eats;
  bit m_wait, m_won, m_eat;

  task automatic model_step(input bit rst, input bit tick, input bit ack, input bit apple_here);
    m_eat = 1'b0;
    if (rst) begin
      m_len = 3; m_eats = 0; m_wait = 1'b0; m_won = 1'b0;
    end else if (m_won) begin
    end else if (m_wait) begin
      if (ack) m_wait = 1'b0;
    end else if (tick && apple_here) begin
      m_eat  = 1'b1;
      m_eats = m_eats + 1;
      m_len  = m_len + 1;
      if (m_len == 16) m_won = 1'b1;
      else m_wait = 1'b1;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    apple_map = '0;
`ifdef APPLE_TRACKER_BODY_COLLISION_EN
    body_map = '0;
`endif

    //   rst tick ack apl ax ay hx hy   eat len sc req won
    add(1, 0, 0, 0,  0,  0,  0,  0,    0, 3, 0, 0, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    1, 4, 1, 1, 0);
    add(0, 0, 0, 1,  5,  5,  5,  5,    0, 4, 1, 1, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    0, 4, 1, 1, 0);
    add(0, 0, 0, 1,  5,  5,  5,  5,    0, 4, 1, 1, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    0, 4, 1, 1, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    0, 4, 1, 1, 0);
    add(0, 1, 1, 1,  5,  5,  5,  5,    0, 4, 1, 0, 0);
    add(0, 1, 0, 1, 12, 12,  2,  4,    0, 4, 1, 0, 0);
    add(1, 0, 0, 0,  0,  0,  0,  0,    0, 3, 0, 0, 0);
    add(0, 1, 0, 1, 12, 12,  2,  4,    0, 3, 0, 0, 0);
    add(0, 1, 0, 1, 15, 15, 15, 15,    1, 4, 1, 1, 0);
    add(0, 0, 1, 0,  0,  0,  0,  0,    0, 4, 1, 0, 0);
    add(0, 0, 1, 0,  0,  0,  0,  0,    0, 4, 1, 0, 0);
    add(0, 1, 0, 0,  0,  0,  3,  3,    0, 4, 1, 0, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    1, 5, 2, 1, 0);
    add(1, 0, 0, 1,  5,  5,  5,  5,    0, 3, 0, 0, 0);
    add(0, 1, 0, 1,  5,  5,  5,  5,    1, 4, 1, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].hx, vecs[i].hy, vecs[i].ack);
      apple_map = '0;
      if (vecs[i].apple) apple_map[vecs[i].ax][vecs[i].ay] = 1'b1;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_eat, vecs[i].e_len, vecs[i].e_score,
              vecs[i].e_req, vecs[i].e_won);
    end

    // Thirteen eats with immediate acks reach the win length.
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    step();
    for (int i = 1; i <= 13; i++) begin
      apple_map = '0;
      apple_map[i][15 - i] = 1'b1;
      drive(1'b0, 1'b1, i, 15 - i, 1'b0);
      step();
      chk_all($sformatf("eat%0d", i), 1'b1, 3 + i, i, (i < 13), (i == 13));
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      step();
      chk_all($sformatf("ack%0d", i), 1'b0, 3 + i, i, 1'b0, (i == 13));
    end
    for (int i = 0; i < 3; i++) begin
      apple_map = '1;
      drive(1'b0, 1'b1, i, i, i[0]);
      step();
      chk_all($sformatf("won%0d", i), 1'b0, 16, 13, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    step();
    chk_all("won_reset", 1'b0, 3, 0, 1'b0, 1'b0);

`ifdef APPLE_TRACKER_BODY_COLLISION_EN
    apple_map = '0; body_map = '0;
    apple_map[7][3] = 1'b1; body_map[7][3] = 1'b1;
    drive(1'b0, 1'b1, 7, 3, 1'b0);
    step();
    chk_all("body", 1'b0, 3, 0, 1'b0, 1'b0);
    chk("body.over", int'(game_over), 1);
    apple_map[1][1] = 1'b1;
    drive(1'b0, 1'b1, 1, 1, 1'b0);
    step();
    chk_all("lost", 1'b0, 3, 0, 1'b0, 1'b0);
    body_map = '0;
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    step();
    chk("lost_reset.over", int'(game_over), 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      bit rst, tick, ack;
      int hx, hy;
      rst  = (c == 0) || ($urandom_range(0, 99) < 2);
      tick = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 2) == 0);
      hx   = $urandom_range(0, 15);
      hy   = $urandom_range(0, 15);
      for (int x = 0; x < 16; x++) apple_map[x] = 16'($urandom & $urandom);
      model_step(rst, tick, ack, apple_map[hx][hy]);
      drive(rst, tick, hx, hy, ack);
      step();
      chk("rnd.eat", int'(eat_pulse), int'(m_eat));
      chk("rnd.len", int'(snake_len), m_len);
      chk("rnd.score", int'(score), m_eats);
      chk("rnd.req", int'(spawn_req), int'(m_wait));
      chk("rnd.won", int'(game_won), int'(m_won));
      chk("rnd.len2", int'(snake_len2), m_len);
      chk("rnd.eat2", int'(eat_pulse2), int'(m_eat));
      chk("rnd.req2", int'(spawn_req2), int'(m_wait));
      chk("rnd.won2", int'(game_won2), int'(m_won));
      chk("rnd.score_sat", int'(score2), (m_eats > 3) ? 3 : m_eats);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/apple_tracker.md
Name: apple_tracker

Overview:
- Parametrised apple-eating and growth tracker for the snake game.
- Samples the snake head against the apple bitmap once per move tick.
- Grows the snake, keeps the score and raises a respawn request to the apple placer using a req/ack handshake.
- Declares a win when the snake reaches maximum length. It sits between the snake movement logic and the LED-matrix pixel driver.

Parameters:
- GRID_W, 16, grid columns (x dimension).
- GRID_H, 16, grid rows (y dimension).
- XW, 4, head_x width; must be at least clog2(GRID_W).
- YW, 4, head_y width; must be at least clog2(GRID_H).
- INIT_LEN, 3, snake length after reset.
- MAX_LEN, 16, length that wins the game; requires INIT_LEN < MAX_LEN < 2**LEN_W.
- LEN_W, 5, snake_len width.
- SCORE_W, 8, score width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- move_tick  input  1  one-cycle strobe: the head has moved to (head_x, head_y).
- head_x  input  XW  head column.
- head_y  input  YW  head row.
- apple_map  input  GRID_W*GRID_H  packed [GRID_W-1:0][GRID_H-1:0], indexed [x][y]; 1 marks an apple.
- spawn_ack  input  1  apple placer has placed a new apple.
- eat_pulse  output  1  one-cycle pulse when an apple is eaten.
- snake_len  output  LEN_W  current length.
- score  output  SCORE_W  apples eaten; saturates at all-ones.
- spawn_req  output  1  request for a new apple; held until acknowledged.
- game_won  output  1  sticky win flag.

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - eat_pulse=0, snake_len=INIT_LEN, score=0, spawn_req=0, game_won=0.
  - State = PLAY.
- Reset overrides everything, including mid-handshake and the WON state.
- hit = move_tick && head_x<GRID_W && head_y<GRID_H && apple_map[head_x][head_y]. An out-of-range head never produces a hit.
- All outputs are registered. Latency from the move_tick edge to eat_pulse, snake_len, score and spawn_req is 1 cycle.
- eat_pulse is 0 in every cycle unless stated below.
- State PLAY:
  - hit with snake_len+1 == MAX_LEN: eat_pulse=1, snake_len=MAX_LEN, score+1, game_won=1, go to WON. spawn_req is not raised.
  - hit with snake_len+1 < MAX_LEN: eat_pulse=1, snake_len+1, score+1, spawn_req=1, go to SPAWN.
  - No hit: hold all values.
- State SPAWN:
  - Hits are ignored, because the apple is in transit and a stale bitmap must not double-count.
  - spawn_req stays 1 until spawn_ack is sampled high. The next cycle then has spawn_req=0 and state=PLAY.
  - A move_tick in the same cycle as spawn_ack is also ignored.
- State WON: terminal. All inputs are ignored, game_won=1, spawn_req=0. Only reset exits.
- spawn_ack sampled outside SPAWN is ignored.
- score saturates at 2**SCORE_W-1. snake_len never exceeds MAX_LEN.
- A held or repeated move_tick on the same apple cell counts only once, because of the SPAWN lockout.

Optional Feature:
- Macro: APPLE_TRACKER_BODY_COLLISION_EN.
- With the macro defined:
  - Adds input body_map (GRID_W*GRID_H, same [x][y] indexing) and output game_over (1 bit, reset 0).
  - Adds state LOST.
  - In PLAY, a move_tick with an in-range head on a set body_map bit gives game_over=1 and a move to LOST the next cycle.
  - Body collision has priority over an apple hit: no eat_pulse, no growth.
  - LOST is terminal until reset. Inputs are ignored and spawn_req=0.
  - Body checks are suppressed in SPAWN and WON.
- Without the macro: neither port exists and there is no LOST state.

Test Plan:
- Reset, apple_map[5][5]=1, head (5,5), move_tick -> next cycle eat_pulse=1, snake_len=4, score=1, spawn_req=1. One cycle later eat_pulse=0.
- In SPAWN: hold head (5,5) with apple still set and pulse move_tick 3 times; spawn_ack arrives 4 cycles later -> snake_len remains 4, score remains 1, spawn_req falls the cycle after ack, state returns to PLAY.
- apple_map[12][12]=1, head (2,4), move_tick -> no eat_pulse, snake_len=3, spawn_req=0. Also: head (15,15) with apple_map[15][15]=1 (corner) -> hit, snake_len=4.
- Eat 13 apples with immediate acks -> 13th eat gives snake_len=16, game_won=1, spawn_req=0. Further hits and move_ticks leave snake_len=16 and score=13.
- Reset asserted while spawn_req=1 -> next cycle spawn_req=0, snake_len=3, score=0, game_won=0. A hit after that is accepted normally.
- (APPLE_TRACKER_BODY_COLLISION_EN) head (7,3) with body_map[7][3]=1 and apple_map[7][3]=1 -> game_over=1, eat_pulse=0, snake_len unchanged. Later hits are ignored until reset.
